pe_group_multicast_reuse_ctrl: RTL
==================================

Name: pe_group_multicast_reuse_ctrl

Overview:
Address/handshake controller for a PE-group input buffer: one writer, NUM_CH reader channels (multicast to several PE groups).
- Each buffered entry is read by every channel cfg_reuse times consecutively (runtime-configurable reuse) before that channel advances.
- An entry slot is recycled only after the slowest channel has retired it.
- Generates write/read addresses internally as ring pointers and sequences one job (start → drain → done) via a small FSM.

Parameters:
ADDR_COUNT, 27, buffer depth in entries (need not be power of 2)
ADDR_W, 5, address width, >= clog2(ADDR_COUNT)
NUM_CH, 4, number of reader channels
REUSE_W, 4, width of reuse configuration/counters
TOTAL_W, 12, width of job write/read totals

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin job (honoured only in IDLE)
cfg_reuse  in  REUSE_W  reads per entry per channel; 0 treated as 1
cfg_total_writes  in  TOTAL_W  entries written in this job
in_valid  in  1  producer has data
in_rdy  out  1  controller accepts write
wen  out  1  in_valid & in_rdy
waddr  out  ADDR_W  current write pointer
out_valid  out  NUM_CH  per-channel entry available
out_rdy  in  NUM_CH  per-channel consumer ready
ren  out  NUM_CH  out_valid & out_rdy per channel
raddr  out  NUM_CH*ADDR_W  per-channel read pointer, channel c at [c*ADDR_W +: ADDR_W]
reuse_idx  out  NUM_CH*REUSE_W  per-channel current reuse iteration (0..reuse-1)
wr_count  out  TOTAL_W  writes accepted this job
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; all pointers, occupancies, reuse counters, wr_count = 0; in_rdy=0, out_valid=0, busy=0, done=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE + start:
  - Latch reuse_q = max(cfg_reuse,1) and total_q = cfg_total_writes.
  - Clear pointers, occupancies and wr_count.
  - Go to RUN, or to DONE if cfg_total_writes==0.
- start outside IDLE is ignored; cfg_* changes after latching are ignored.
- RUN:
  - in_rdy = (wr_count != total_q) & no channel full, where full(c) = occ[c]==ADDR_COUNT.
  - Go to DRAIN in the cycle after wr_count reaches total_q.
- DRAIN: in_rdy=0; go to DONE when all occ[c]==0.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in RUN/DRAIN/DONE.
- out_valid[c] = (occ[c]!=0) in RUN/DRAIN, else 0.
- All ready/valid outputs derive from registered state only. No same-cycle write→read bypass: a write becomes readable the cycle after wen (latency 1).
- On wen:
  - waddr advances, wrapping ADDR_COUNT-1 → 0.
  - wr_count++.
  - Every occ[c]++ unless channel c retires in the same cycle.
- On ren[c]:
  - If reuse_idx[c]==reuse_q-1: retire — reuse_idx[c]←0, raddr[c] advances with wrap, occ[c]--.
  - Otherwise reuse_idx[c]++ and raddr[c] holds.
- Simultaneous wen and retire on channel c: occ[c] unchanged.
- Occupancy: occ[c] width clog2(ADDR_COUNT+1); never exceeds ADDR_COUNT and never underflows.
- Channels are independent. A stalled channel back-pressures the writer only through its own full condition, and a full channel blocks in_rdy even if the others are empty.
- Async reset mid-job aborts immediately with no done pulse.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3) and a pointer-wrap increment function.
- One natural sub-module, pe_group_reuse_rd_chan, instantiated NUM_CH times via generate. It holds raddr, reuse_idx, occ and out_valid/ren logic for one channel, with inputs wen, reuse_q, active.

Test Plan:
- NUM_CH=2, reuse=3, total=4, both out_rdy=1 → each channel reads raddr 0,0,0,1,1,1,2,2,2,3,3,3; reuse_idx cycles 0,1,2; done pulses once; wr_count=4.
- cfg_reuse=0, total=2 → each entry read exactly once per channel.
- ADDR_COUNT=27, total=40, channel 1 out_rdy=0 → in_rdy drops after 27 writes (occ[1]=27). Release out_rdy → writes resume, waddr wraps 26→0, all 40 entries read in order.
- Full buffer, wen and a ch0 retire in the same cycle: in_rdy=0 (registered full), so no write. The next cycle in_rdy=1 only if all channels are below full.
- cfg_total_writes=0 + start → busy for 1 cycle, done pulse, no wen or ren.
- rst_n low mid-RUN (wr_count=5) → all outputs return to reset values asynchronously with no done. A following start with total=3 runs cleanly from waddr=0.

Source files
------------

// File: rtl/pe_group_multicast_reuse_ctrl_pkg.sv
// Shared definitions for the PE-group multicast reuse controller.
//   state_t      : job sequencing FSM encoding
//   ptr_wrap_inc : ring-pointer increment that wraps at an arbitrary last index
package pe_group_multicast_reuse_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pointers are widened to 16 bits so one helper serves every address width.
  function automatic logic [15:0] ptr_wrap_inc(input logic [15:0] ptr,
                                               input logic [15:0] last);
    logic [15:0] nxt;
    if (ptr == last) begin
      nxt = 16'd0;
    end else begin
      nxt = ptr + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pe_group_reuse_rd_chan.sv
// One reader channel of the multicast buffer.
// Tracks this channel's read pointer, its reuse iteration within the current
// entry and how many written entries it has not yet retired.
//   clr       : clear all channel state (job start)
//   active    : controller is in RUN or DRAIN
//   wen       : writer pushed an entry this cycle
//   reuse_q   : reads per entry (already forced >= 1)
//   out_rdy   : consumer ready; out_valid / ren : handshake outputs
//   raddr     : read pointer; reuse_idx : current iteration
//   full      : occupancy reached the buffer depth; empty : nothing pending
module pe_group_reuse_rd_chan
  import pe_group_multicast_reuse_ctrl_pkg::*;
#(
  parameter int ADDR_COUNT = 27,
  parameter int ADDR_W     = 5,
  parameter int REUSE_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               active,
  input  logic               wen,
  input  logic [REUSE_W-1:0] reuse_q,
  input  logic               out_rdy,
  output logic               out_valid,
  output logic               ren,
  output logic [ADDR_W-1:0]  raddr,
  output logic [REUSE_W-1:0] reuse_idx,
  output logic               full,
  output logic               empty
);

  localparam int OCC_W = $clog2(ADDR_COUNT + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(ADDR_COUNT);
  localparam logic [15:0] LAST_ADDR = 16'(ADDR_COUNT - 1);

  logic [OCC_W-1:0]   occ_r;
  logic [ADDR_W-1:0]  raddr_r;
  logic [REUSE_W-1:0] reuse_idx_r;
  logic               retire_s;

  // Valid depends only on registered occupancy, so a write is readable
  // the cycle after it lands.
  assign out_valid = active & (occ_r != '0);
  assign ren       = out_valid & out_rdy;
  assign retire_s  = ren & (reuse_idx_r == (reuse_q - REUSE_W'(1)));
  assign full      = (occ_r == OCC_MAX);
  assign empty     = (occ_r == '0);
  assign raddr     = raddr_r;
  assign reuse_idx = reuse_idx_r;

  // Read pointer, reuse iteration and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r       <= '0;
      raddr_r     <= '0;
      reuse_idx_r <= '0;
    end else if (clr) begin
      occ_r       <= '0;
      raddr_r     <= '0;
      reuse_idx_r <= '0;
    end else begin
      if (retire_s) begin
        reuse_idx_r <= '0;
        raddr_r     <= ADDR_W'(ptr_wrap_inc(16'(raddr_r), LAST_ADDR));
      end else if (ren) begin
        reuse_idx_r <= reuse_idx_r + REUSE_W'(1);
      end
      // A write and a retire in the same cycle cancel out.
      case ({wen, retire_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/pe_group_multicast_reuse_ctrl.sv
// Address/handshake controller for a PE-group input buffer with one writer
// and NUM_CH multicast reader channels. Each entry is read reuse times by
// every channel; a slot is recycled only after the slowest channel retires it.
//   start / cfg_reuse / cfg_total_writes : job launch and configuration
//   in_valid / in_rdy / wen / waddr      : writer side
//   out_valid / out_rdy / ren / raddr / reuse_idx : per-channel reader side
//   wr_count : writes accepted this job; busy / done : job status
module pe_group_multicast_reuse_ctrl
  import pe_group_multicast_reuse_ctrl_pkg::*;
#(
  parameter int ADDR_COUNT = 27,
  parameter int ADDR_W     = 5,
  parameter int NUM_CH     = 4,
  parameter int REUSE_W    = 4,
  parameter int TOTAL_W    = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [REUSE_W-1:0]          cfg_reuse,
  input  logic [TOTAL_W-1:0]          cfg_total_writes,
  input  logic                        in_valid,
  output logic                        in_rdy,
  output logic                        wen,
  output logic [ADDR_W-1:0]           waddr,
  output logic [NUM_CH-1:0]           out_valid,
  input  logic [NUM_CH-1:0]           out_rdy,
  output logic [NUM_CH-1:0]           ren,
  output logic [NUM_CH*ADDR_W-1:0]    raddr,
  output logic [NUM_CH*REUSE_W-1:0]   reuse_idx,
  output logic [TOTAL_W-1:0]          wr_count,
  output logic                        busy,
  output logic                        done
);

  localparam logic [15:0] LAST_ADDR = 16'(ADDR_COUNT - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [REUSE_W-1:0]   reuse_q_r;
  logic [TOTAL_W-1:0]   total_q_r;
  logic [TOTAL_W-1:0]   wr_count_r;
  logic [ADDR_W-1:0]    waddr_r;
  logic                 clr_s;
  logic                 active_s;
  logic [NUM_CH-1:0]    full_s;
  logic [NUM_CH-1:0]    empty_s;

  assign clr_s    = (state_r == ST_IDLE) & start;
  assign active_s = (state_r == ST_RUN) | (state_r == ST_DRAIN);
  // Any single full channel stalls the writer, regardless of the others.
  assign in_rdy   = (state_r == ST_RUN) & (wr_count_r != total_q_r) & ~(|full_s);
  assign wen      = in_valid & in_rdy;
  assign waddr    = waddr_r;
  assign wr_count = wr_count_r;
  assign busy     = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_chan
      pe_group_reuse_rd_chan #(
        .ADDR_COUNT (ADDR_COUNT),
        .ADDR_W     (ADDR_W),
        .REUSE_W    (REUSE_W)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .active    (active_s),
        .wen       (wen),
        .reuse_q   (reuse_q_r),
        .out_rdy   (out_rdy[gc]),
        .out_valid (out_valid[gc]),
        .ren       (ren[gc]),
        .raddr     (raddr[gc*ADDR_W +: ADDR_W]),
        .reuse_idx (reuse_idx[gc*REUSE_W +: REUSE_W]),
        .full      (full_s[gc]),
        .empty     (empty_s[gc])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (cfg_total_writes == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wr_count_r == total_q_r) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (&empty_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Job configuration latch, write pointer and write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reuse_q_r  <= REUSE_W'(1);
      total_q_r  <= '0;
      wr_count_r <= '0;
      waddr_r    <= '0;
    end else if (clr_s) begin
      reuse_q_r  <= (cfg_reuse == '0) ? REUSE_W'(1) : cfg_reuse;
      total_q_r  <= cfg_total_writes;
      wr_count_r <= '0;
      waddr_r    <= '0;
    end else if (wen) begin
      wr_count_r <= wr_count_r + TOTAL_W'(1);
      waddr_r    <= ADDR_W'(ptr_wrap_inc(16'(waddr_r), LAST_ADDR));
    end
  end

endmodule
